// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler: warp FSM states, fetcher status and
// instruction address type, plus a helper that tells whether a state owns the slot.
package warp_scheduler_pkg;

  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    READY    = 3'd3,
    EXECUTE  = 3'd4,
    WAIT_MEM = 3'd5,
    UPDATE   = 3'd6,
    DONE     = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'd0,
    FETCHER_FETCHING = 2'd1,
    FETCHER_FETCHED  = 2'd2
  } fetcher_state_t;

  function automatic logic holds_slot(input warp_state_t s);
    return (s == EXECUTE) || (s == WAIT_MEM) || (s == UPDATE);
  endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping.
// N must be a power of two so that the index arithmetic wraps naturally.
module rr_arbiter
  import warp_scheduler_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] idx_s;

  // Scan downward from the farthest offset so the nearest requester overwrites last.
  always_comb begin
    idx_s       = {IW{1'b0}};
    grant_idx   = {IW{1'b0}};
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s       = ptr + IW'(k);
      grant_idx   = req[idx_s] ? idx_s : grant_idx;
      grant_valid = grant_valid | req[idx_s];
    end
    grant = grant_valid ? (N'(1) << grant_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp sequencer with round-robin ownership of the shared execution slot.
// Optional WARP_SCHED_PERF_EN adds saturating busy/stall cycle counters.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int WARPS_PER_CORE   = 4,
  parameter int THREADS_PER_WARP = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  output logic                                    done,
  input  logic [$clog2(WARPS_PER_CORE+1)-1:0]     num_warps,
  input  instruction_memory_address_t             start_pc,
  input  fetcher_state_t                          fetcher_state [WARPS_PER_CORE],
  input  logic [WARPS_PER_CORE-1:0]               instr_is_ret,
  input  logic [WARPS_PER_CORE-1:0]               instr_is_mem,
  input  logic                                    lsu_done,
  input  logic                                    branch_taken,
  input  instruction_memory_address_t             branch_target,
  output warp_state_t                             warp_state [WARPS_PER_CORE],
  output instruction_memory_address_t             pc [WARPS_PER_CORE],
  output logic [$clog2(WARPS_PER_CORE)-1:0]       current_warp
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0]                             busy_cycles,
  output logic [31:0]                             stall_cycles
`endif
);

  localparam int IDX_W = $clog2(WARPS_PER_CORE);
  localparam int CNT_W = $clog2(WARPS_PER_CORE + 1);

  // Thread count only sizes the datapath outside this block.
  if (THREADS_PER_WARP < 1) begin : g_no_threads
  end

  logic [WARPS_PER_CORE-1:0]   ready_s;
  logic [WARPS_PER_CORE-1:0]   req_s;
  logic [WARPS_PER_CORE-1:0]   grant_s;
  logic [IDX_W-1:0]            grant_idx_s;
  logic [IDX_W-1:0]            rr_ptr_r;
  logic                        grant_valid_s;
  logic                        busy_s;
  logic                        all_idle_s;
  logic                        all_done_s;
  logic                        start_ok_s;
  warp_state_t                 state_nxt_s [WARPS_PER_CORE];
  instruction_memory_address_t pc_nxt_s [WARPS_PER_CORE];

  // Slot occupancy, ready requests and block-level idle/done status.
  always_comb begin
    busy_s     = 1'b0;
    all_idle_s = 1'b1;
    all_done_s = 1'b1;
    ready_s    = {WARPS_PER_CORE{1'b0}};
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      busy_s     = busy_s | holds_slot(warp_state[i]);
      all_idle_s = all_idle_s & (warp_state[i] == IDLE);
      all_done_s = all_done_s & (warp_state[i] == DONE);
      ready_s[i] = (warp_state[i] == READY);
    end
  end

  assign start_ok_s = start & (all_idle_s | all_done_s);
  assign req_s      = busy_s ? {WARPS_PER_CORE{1'b0}} : ready_s;
  assign done       = all_done_s;

  rr_arbiter #(.N(WARPS_PER_CORE)) u_arb (
    .req         (req_s),
    .ptr         (rr_ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Per-warp next state and PC; an accepted start overrides every warp.
  always_comb begin
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      state_nxt_s[i] = warp_state[i];
      pc_nxt_s[i]    = pc[i];
      if (start_ok_s) begin
        state_nxt_s[i] = (CNT_W'(i) < num_warps) ? FETCH : DONE;
        pc_nxt_s[i]    = (CNT_W'(i) < num_warps) ? start_pc : pc[i];
      end else begin
        case (warp_state[i])
          FETCH:    state_nxt_s[i] = (fetcher_state[i] == FETCHER_FETCHED) ? DECODE : FETCH;
          DECODE:   state_nxt_s[i] = instr_is_ret[i] ? DONE : READY;
          READY:    state_nxt_s[i] = grant_s[i] ? EXECUTE : READY;
          EXECUTE:  state_nxt_s[i] = instr_is_mem[i] ? WAIT_MEM : UPDATE;
          WAIT_MEM: state_nxt_s[i] = lsu_done ? UPDATE : WAIT_MEM;
          UPDATE: begin
            state_nxt_s[i] = FETCH;
            pc_nxt_s[i]    = branch_taken ? branch_target : pc[i] + ADDR_W'(1);
          end
          default:  state_nxt_s[i] = warp_state[i];
        endcase
      end
    end
  end

  // Warp state, PC, slot owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WARPS_PER_CORE; i++) begin
        warp_state[i] <= IDLE;
        pc[i]         <= {ADDR_W{1'b0}};
      end
      current_warp <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
    end else begin
      warp_state <= state_nxt_s;
      pc         <= pc_nxt_s;
      if (grant_valid_s) begin
        current_warp <= grant_idx_s;
        rr_ptr_r     <= grant_idx_s + IDX_W'(1);
      end
    end
  end

`ifdef WARP_SCHED_PERF_EN
  // Saturating slot-busy and ready-but-ungranted counters, cleared on launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cycles  <= 32'd0;
      stall_cycles <= 32'd0;
    end else if (start_ok_s) begin
      busy_cycles  <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (busy_s && (busy_cycles != 32'hFFFF_FFFF)) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
      if ((|ready_s) && !grant_valid_s && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the warp lifecycle.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  localparam int W = 4;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        start;
  logic                        done;
  logic [2:0]                  num_warps;
  instruction_memory_address_t start_pc;
  fetcher_state_t              fetcher_state [W];
  logic [W-1:0]                instr_is_ret;
  logic [W-1:0]                instr_is_mem;
  logic                        lsu_done;
  logic                        branch_taken;
  instruction_memory_address_t branch_target;
  warp_state_t                 warp_state [W];
  instruction_memory_address_t pc [W];
  logic [1:0]                  current_warp;
`ifdef WARP_SCHED_PERF_EN
  logic [31:0]                 busy_cycles;
  logic [31:0]                 stall_cycles;
`endif

  int compared = 0;
  int failed = 0;
  int cyc = 0;

  warp_state_t m_state [W];
  int          m_pc [W];
  int          m_cur;
  int          m_rr;
  longint      m_busy;
  longint      m_stall;

  warp_scheduler #(.WARPS_PER_CORE(W), .THREADS_PER_WARP(32)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .num_warps(num_warps),
    .start_pc(start_pc), .fetcher_state(fetcher_state), .instr_is_ret(instr_is_ret),
    .instr_is_mem(instr_is_mem), .lsu_done(lsu_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .warp_state(warp_state), .pc(pc),
    .current_warp(current_warp)
`ifdef WARP_SCHED_PERF_EN
    , .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_state[i] = IDLE;
      m_pc[i] = 0;
    end
    m_cur = 0;
    m_rr = 0;
    m_busy = 0;
    m_stall = 0;
  endtask

  // One clock edge of the warp lifecycle as described by the block's rules.
  task automatic model_edge();
    warp_state_t ns [W];
    int npc [W];
    bit busy;
    bit all_idle;
    bit all_done;
    bit any_ready;
    int winner;
    busy = 0; all_idle = 1; all_done = 1; any_ready = 0; winner = -1;
    for (int i = 0; i < W; i++) begin
      if (m_state[i] inside {EXECUTE, WAIT_MEM, UPDATE}) busy = 1;
      if (m_state[i] != IDLE) all_idle = 0;
      if (m_state[i] != DONE) all_done = 0;
      if (m_state[i] == READY) any_ready = 1;
      ns[i] = m_state[i];
      npc[i] = m_pc[i];
    end
    if (!busy)
      for (int k = 0; k < W; k++)
        if (winner < 0 && m_state[(m_rr + k) % W] == READY) winner = (m_rr + k) % W;
    if (start && (all_idle || all_done)) begin
      for (int i = 0; i < W; i++) begin
        if (i < num_warps) begin
          ns[i] = FETCH;
          npc[i] = start_pc;
        end else ns[i] = DONE;
      end
      m_busy = 0;
      m_stall = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        case (m_state[i])
          FETCH:    if (fetcher_state[i] == FETCHER_FETCHED) ns[i] = DECODE;
          DECODE:   ns[i] = instr_is_ret[i] ? DONE : READY;
          READY:    if (i == winner) ns[i] = EXECUTE;
          EXECUTE:  ns[i] = instr_is_mem[i] ? WAIT_MEM : UPDATE;
          WAIT_MEM: if (lsu_done) ns[i] = UPDATE;
          UPDATE: begin
            ns[i] = FETCH;
            npc[i] = branch_taken ? int'(branch_target) : (m_pc[i] + 1) % 256;
          end
          default: ;
        endcase
      end
      if (busy && m_busy < 64'hFFFF_FFFF) m_busy++;
      if (any_ready && winner < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    if (winner >= 0) begin
      m_cur = winner;
      m_rr = (winner + 1) % W;
    end
    m_state = ns;
    m_pc = npc;
  endtask

  function automatic logic [46:0] dut_snap();
    logic [46:0] s;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i*3 +: 3] = warp_state[i];
      s[12 + i*8 +: 8] = pc[i];
    end
    s[45:44] = current_warp;
    s[46] = done;
    return s;
  endfunction

  function automatic logic [46:0] mdl_snap();
    logic [46:0] s;
    logic all_done;
    s = '0;
    all_done = 1'b1;
    for (int i = 0; i < W; i++) begin
      s[i*3 +: 3] = m_state[i];
      s[12 + i*8 +: 8] = m_pc[i][7:0];
      if (m_state[i] != DONE) all_done = 1'b0;
    end
    s[45:44] = m_cur[1:0];
    s[46] = all_done;
    return s;
  endfunction

  function automatic int slot_owners();
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (warp_state[i] inside {EXECUTE, WAIT_MEM, UPDATE}) n++;
    return n;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; num_warps = 3'd0; start_pc = 8'd0;
    for (int i = 0; i < W; i++) fetcher_state[i] = FETCHER_FETCHING;
    instr_is_ret = 4'b0000; instr_is_mem = 4'b0000;
    lsu_done = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic launch(input logic [2:0] n, input logic [7:0] spc);
    num_warps = n; start_pc = spc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (dut_snap() !== mdl_snap()) begin
      failed++; $display("FAIL reset_state got=%h exp=%h", dut_snap(), mdl_snap());
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_warp(input bit do_reset);
    int wm;
    bit fin;
    int pcs[$];
    int exp_pcs[3];
    wm = 0; fin = 0; exp_pcs = '{0, 1, 2};
    if (do_reset) apply_reset();
    for (int i = 0; i < W; i++) fetcher_state[i] = FETCHER_FETCHED;
    launch(3'd1, 8'd0);
    compared++;
    if (warp_state[0] !== FETCH || warp_state[1] !== DONE || warp_state[2] !== DONE || warp_state[3] !== DONE) begin
      failed++; $display("FAIL single_after_start got=%h exp=%h", dut_snap(), mdl_snap());
    end
    pcs.push_back(int'(pc[0]));
    for (int c = 0; c < 60 && !fin; c++) begin
      instr_is_ret = {3'b000, (m_pc[0] == 2)};
      tick();
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc, dut_snap(), mdl_snap());
      end
      if (warp_state[0] == WAIT_MEM) wm++;
      if (int'(pc[0]) != pcs[$]) pcs.push_back(int'(pc[0]));
      if (done === 1'b1) fin = 1;
    end
    compared++;
    if (!fin) begin failed++; $display("FAIL single_timeout done=%b exp=1", done); end
    compared++;
    if (pcs.size() != 3 || pcs[0] != exp_pcs[0] || pcs[1] != exp_pcs[1] || pcs[2] != exp_pcs[2]) begin
      failed++; $display("FAIL single_pc_seq got=%p exp=%p", pcs, exp_pcs);
    end
    compared++;
    if (wm != 0) begin failed++; $display("FAIL single_no_waitmem got=%0d exp=0", wm); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < W; i++) fetcher_state[i] = FETCHER_FETCHED;
    launch(3'd4, 8'd20);
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL rr_cycle cyc=%0d got=%h exp=%h", cyc, dut_snap(), mdl_snap());
      end
      compared++;
      if (slot_owners() > 1) begin failed++; $display("FAIL rr_single_owner got=%0d exp<=1", slot_owners()); end
      for (int i = 0; i < W; i++)
        if (warp_state[i] == EXECUTE) begin
          order.push_back(i);
          compared++;
          if (current_warp !== 2'(i)) begin
            failed++; $display("FAIL rr_current_warp got=%0d exp=%0d", current_warp, i);
          end
        end
    end
    compared++;
    if (order.size() < 5) begin
      failed++; $display("FAIL rr_grant_count got=%0d exp=5", order.size());
    end else
      for (int k = 0; k < 5; k++) begin
        compared++;
        if (order[k] != exp_order[k]) begin
          failed++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
        end
      end
  endtask

  task automatic test_mem_wait();
    int wm_m;
    int dut_wm;
    int upd_cyc;
    int ex1_cyc;
    wm_m = 0; dut_wm = 0; upd_cyc = -1; ex1_cyc = -1;
    apply_reset();
    for (int i = 0; i < W; i++) fetcher_state[i] = FETCHER_FETCHED;
    launch(3'd3, 8'd0);
    for (int c = 0; c < 80 && ex1_cyc < 0; c++) begin
      instr_is_mem = {3'b000, (m_pc[0] == 0)};
      lsu_done = (m_state[0] == WAIT_MEM) ? (wm_m == 5) : 1'b1;
      branch_taken = 1'($urandom_range(0, 1)) & (m_state[0] != UPDATE);
      tick();
      wm_m = (m_state[0] == WAIT_MEM) ? wm_m + 1 : 0;
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL mem_cycle cyc=%0d got=%h exp=%h", cyc, dut_snap(), mdl_snap());
      end
      compared++;
      if (slot_owners() > 1) begin failed++; $display("FAIL mem_single_owner got=%0d exp<=1", slot_owners()); end
      if (warp_state[0] == WAIT_MEM) dut_wm++;
      if (warp_state[0] == UPDATE && upd_cyc < 0) upd_cyc = cyc;
      if (warp_state[1] == EXECUTE && ex1_cyc < 0) ex1_cyc = cyc;
    end
    compared++;
    if (dut_wm != 5) begin failed++; $display("FAIL mem_wait_len got=%0d exp=5", dut_wm); end
    compared++;
    if (ex1_cyc < 0 || upd_cyc < 0 || ex1_cyc - upd_cyc != 2) begin
      failed++; $display("FAIL mem_next_grant_gap got=%0d exp=2", ex1_cyc - upd_cyc);
    end
  endtask

  task automatic run_update(input logic [7:0] spc, input bit taken, input logic [7:0] tgt,
                            input logic [7:0] exp_pc, input string name);
    bit seen;
    bit checked;
    seen = 0; checked = 0;
    apply_reset();
    fetcher_state[0] = FETCHER_FETCHED;
    launch(3'd1, spc);
    for (int c = 0; c < 20 && !checked; c++) begin
      branch_taken = (m_state[0] == UPDATE) ? taken : 1'($urandom_range(0, 1));
      branch_target = (m_state[0] == UPDATE) ? tgt : 8'($urandom);
      tick();
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL %s_cycle cyc=%0d got=%h exp=%h", name, cyc, dut_snap(), mdl_snap());
      end
      if (seen) begin
        checked = 1;
        compared++;
        if (pc[0] !== exp_pc) begin failed++; $display("FAIL %s_pc got=%h exp=%h", name, pc[0], exp_pc); end
      end
      if (warp_state[0] == UPDATE) seen = 1;
    end
    compared++;
    if (!checked) begin failed++; $display("FAIL %s_timeout got=0 exp=1", name); end
  endtask

  task automatic test_branch_wrap();
    run_update(8'h05, 1'b1, 8'h10, 8'h10, "branch");
    run_update(8'hFF, 1'b0, 8'h33, 8'h00, "wrap");
  endtask

  task automatic test_partial_block();
    bit fin;
    fin = 0;
    apply_reset();
    launch(3'd2, 8'd0);
    compared++;
    if (warp_state[2] !== DONE || warp_state[3] !== DONE || done !== 1'b0) begin
      failed++; $display("FAIL partial_after_start got=%h exp=%h", dut_snap(), mdl_snap());
    end
    for (int c = 0; c < 100 && !fin; c++) begin
      for (int i = 0; i < W; i++)
        fetcher_state[i] = ($urandom_range(0, 2) == 0) ? FETCHER_FETCHING : FETCHER_FETCHED;
      instr_is_ret = {2'b00, (m_pc[1] == 2), (m_pc[0] == 1)};
      start = (c == 6);
      num_warps = 3'd4;
      tick();
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL partial_cycle cyc=%0d got=%h exp=%h", cyc, dut_snap(), mdl_snap());
      end
      if (done === 1'b1) fin = 1;
    end
    start = 1'b0;
    compared++;
    if (!fin) begin failed++; $display("FAIL partial_timeout done=%b exp=1", done); end
  endtask

  task automatic test_zero_warps();
    apply_reset();
    launch(3'd0, 8'd7);
    compared++;
    if (done !== 1'b1 || dut_snap() !== mdl_snap()) begin
      failed++; $display("FAIL zero_done got=%h exp=%h", dut_snap(), mdl_snap());
    end
    launch(3'd4, 8'd9);
    compared++;
    if (done !== 1'b0 || dut_snap() !== mdl_snap()) begin
      failed++; $display("FAIL relaunch got=%h exp=%h", dut_snap(), mdl_snap());
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    apply_reset();
    fetcher_state[0] = FETCHER_FETCHED;
    instr_is_mem = 4'b0001;
    launch(3'd1, 8'd40);
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (warp_state[0] == WAIT_MEM) hit = 1;
    end
    compared++;
    if (!hit) begin failed++; $display("FAIL resetmid_reach_waitmem got=0 exp=1"); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (warp_state[0] !== IDLE || pc[0] !== 8'd0 || done !== 1'b0 || current_warp !== 2'd0 ||
        dut_snap() !== mdl_snap()) begin
      failed++; $display("FAIL resetmid_state got=%h exp=%h", dut_snap(), mdl_snap());
    end
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    test_single_warp(1'b0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 9) == 0);
      num_warps = 3'($urandom_range(0, 4));
      start_pc = 8'($urandom);
      for (int i = 0; i < W; i++) begin
        fetcher_state[i] = ($urandom_range(0, 2) == 0) ? FETCHER_FETCHING : FETCHER_FETCHED;
        instr_is_ret[i] = ($urandom_range(0, 7) == 0);
        instr_is_mem[i] = ($urandom_range(0, 2) == 0);
      end
      lsu_done = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      branch_target = 8'($urandom);
      tick();
      compared++;
      if (dut_snap() !== mdl_snap()) begin
        failed++; $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, dut_snap(), mdl_snap());
      end
`ifdef WARP_SCHED_PERF_EN
      compared++;
      if (busy_cycles !== 32'(m_busy) || stall_cycles !== 32'(m_stall)) begin
        failed++; $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d", busy_cycles, stall_cycles, m_busy, m_stall);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_warp(1'b1);
    test_round_robin();
    test_mem_wait();
    test_branch_wrap();
    test_partial_block();
    test_zero_warps();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-core warp sequencer: advances every warp through fetch, decode, execute, memory-wait and PC update.
- Arbitrates the single shared execution slot (per-thread ALU/LSU bank) between ready warps using round-robin.
- Sits inside compute_core between the per-warp fetchers and the shared ALU/LSU bank.
- Drives warp_state, pc and current_warp; raises done when the block's warps have all retired.

Parameters:
- WARPS_PER_CORE, 4, number of warps sequenced (power of two, ≥2)
- THREADS_PER_WARP, 32, threads per warp; carried for consistency, not used in logic

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch pulse for the block
- done  output  1  all warps in DONE
- num_warps  input  $clog2(WARPS_PER_CORE+1)  active warps this block, from kernel_config
- start_pc  input  instruction_memory_address_t  initial PC for every active warp
- fetcher_state  input  fetcher_state_t[WARPS_PER_CORE]  per-warp fetcher status
- instr_is_ret  input  [WARPS_PER_CORE]  decoded instruction of warp i is RET (sampled in DECODE)
- instr_is_mem  input  [WARPS_PER_CORE]  decoded instruction of warp i uses the LSU
- lsu_done  input  1  LSU bank finished the current warp's access
- branch_taken  input  1  current warp's instruction redirects the PC (sampled in UPDATE)
- branch_target  input  instruction_memory_address_t  redirect address
- warp_state  output  warp_state_t[WARPS_PER_CORE]  per-warp state
- pc  output  instruction_memory_address_t[WARPS_PER_CORE]  per-warp PC
- current_warp  output  $clog2(WARPS_PER_CORE)  warp owning or last owning the execution slot

Behaviour:
- Reset (reset=0, async):
  - all warp_state=IDLE, pc=0, current_warp=0, done=0
  - round-robin pointer rr_ptr=0
- Per-warp FSM:
  - IDLE: on start, warp i<num_warps → FETCH with pc=start_pc; warp i≥num_warps → DONE.
  - FETCH: fetcher_state[i]==FETCHED → DECODE.
  - DECODE: exactly 1 cycle. instr_is_ret[i] → DONE; otherwise → READY.
  - READY: held until granted; grant → EXECUTE.
  - EXECUTE: exactly 1 cycle. instr_is_mem[i] → WAIT_MEM; otherwise → UPDATE.
  - WAIT_MEM: lsu_done → UPDATE; with no lsu_done, wait indefinitely.
  - UPDATE: exactly 1 cycle. pc ← branch_taken ? branch_target : pc+1 (modulo address width; wraps max→0). Next state FETCH.
  - DONE: sticky until the next accepted start.
- Execution-slot arbitration:
  - Slot is busy when any warp is in EXECUTE, WAIT_MEM or UPDATE; at most one warp holds it.
  - When the slot is free and ≥1 warp is READY, exactly one is granted at the next edge.
  - Winner is the first READY warp scanning from rr_ptr upward, wrapping.
  - On grant: current_warp ← winner, rr_ptr ← winner+1 (wrap).
  - No grant in the cycle a warp sits in UPDATE, so back-to-back grants are 1 idle cycle apart.
- done: combinational AND of (warp_state==DONE) across all warps.
- start handling:
  - accepted only when all warps are IDLE or all are DONE; ignored while any warp is active.
  - start with done=1 relaunches: all active warps → FETCH, done drops the next cycle.
- num_warps=0 with start: all warps → DONE, done=1 the cycle after start.
- branch_taken and branch_target are ignored outside UPDATE; lsu_done is ignored outside WAIT_MEM.
- reset mid-operation: immediate return to the reset values above; a pending LSU access is abandoned.

Optional Feature:
- Macro WARP_SCHED_PERF_EN.
- Defined:
  - adds outputs busy_cycles and stall_cycles, each 32-bit, saturating.
  - busy_cycles counts cycles the slot is busy.
  - stall_cycles counts cycles where some warp is READY but none is granted.
  - both clear on reset and on an accepted start.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Common package holds:
  - warp_state_t enum: IDLE, FETCH, DECODE, READY, EXECUTE, WAIT_MEM, UPDATE, DONE
  - fetcher_state_t
  - instruction_memory_address_t
- Sub-module rr_arbiter (parameter N): request vector plus pointer in → one-hot grant and index out, purely combinational. Scheduler owns rr_ptr.

Test Plan:
- num_warps=1, start_pc=0, ALU, ALU, RET → pc sequence 0,1,2. Warp 0 reaches DONE, warps 1–3 DONE after start, done=1. No WAIT_MEM seen.
- num_warps=4, all reach READY in the same cycle → grant order 0,1,2,3,0. current_warp matches each grant. At most one warp ever in EXECUTE/WAIT_MEM/UPDATE.
- Warp 0 is a mem instruction with lsu_done 5 cycles after WAIT_MEM entry, warps 1–2 READY → warp 0 holds WAIT_MEM 5 cycles with no other grant. Warp 1 is granted 1 cycle after warp 0's UPDATE.
- branch_taken=1, branch_target=0x10 in UPDATE → pc=0x10. Separately, pc=max address, no branch → pc wraps to 0.
- num_warps=2, WARPS_PER_CORE=4 → warps 2,3 go DONE the cycle after start. done rises only after warps 0 and 1 decode RET. A start pulse while warps are active is ignored.
- reset driven low while warp 0 is in WAIT_MEM → same cycle: all IDLE, pc=0, done=0, current_warp=0. After reset releases, a fresh start behaves as in test 1.
